mult_operand_shifter: RTL and testbench

- Holds both operands of the sequential shift-and-add unsigned multiplier.
- Left channel: loads the multiplicand and shifts it left one bit per enabled cycle, producing the aligned partial-product addend.
- Right channel: loads the multiplier and shifts it right one bit per enabled cycle, exposing its LSB and an all-zero flag to the controller.
- Sits between the operand inputs and the product accumulator/controller.

---
 rtl/mult_operand_shifter_pkg.sv | 15 +
 rtl/mult_operand_shifter_if.sv | 36 +++
 rtl/mult_operand_shifter_shift_reg.sv | 31 +++
 rtl/mult_operand_shifter.sv | 69 ++++++
 tb/tb_mult_operand_shifter.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/mult_operand_shifter_pkg.sv
// Shared widths and operand types for the shift-and-add multiplier datapath.
package mult_pkg;

    localparam int MULT_WIDTH      = 8;
    localparam int MULT_PROD_WIDTH = 2 * MULT_WIDTH - 1;

    typedef logic [MULT_WIDTH-1:0]      operand_t;
    typedef logic [MULT_PROD_WIDTH-1:0] addend_t;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_t;

endpackage

// File: rtl/mult_operand_shifter_if.sv
// Operand/handshake bundle between the multiplier controller (master) and the operand shifter (slave).
// The done signal exists only when MULT_SHIFT_DONE_EN is defined.
interface mult_operand_shifter_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               load;
    logic               shift_en;
    logic [2*WIDTH-2:0] shifted_multiplicand;
    logic [WIDTH-1:0]   shifted_multiplier;
    logic               lsb_multiplier;
    logic               zflag;
`ifdef MULT_SHIFT_DONE_EN
    logic               done;
`endif

    modport master (
        output multiplicand, multiplier, load, shift_en,
        input  shifted_multiplicand, shifted_multiplier, lsb_multiplier, zflag
`ifdef MULT_SHIFT_DONE_EN
        , input done
`endif
    );

    modport slave (
        input  multiplicand, multiplier, load, shift_en,
        output shifted_multiplicand, shifted_multiplier, lsb_multiplier, zflag
`ifdef MULT_SHIFT_DONE_EN
        , output done
`endif
    );

endinterface

// File: rtl/mult_operand_shifter_shift_reg.sv
// Loadable one-bit-per-cycle shift register; the operand is zero-extended on load and zero-filled on shift.
module shift_reg_1b
    import mult_pkg::*;
#(
    parameter int         REG_W = 15,
    parameter int         IN_W  = 8,
    parameter shift_dir_t DIR   = SHIFT_LEFT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [IN_W-1:0]  din,
    output logic [REG_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= REG_W'(din);
        end else if (shift_en) begin
            if (DIR == SHIFT_LEFT) begin
                q <= {q[REG_W-2:0], 1'b0};
            end else begin
                q <= {1'b0, q[REG_W-1:1]};
            end
        end
    end

endmodule

// File: rtl/mult_operand_shifter.sv
// Operand shifter for the sequential unsigned multiplier: left channel holds the aligned addend,
// right channel exposes the next multiplier bit. Optional done flag under MULT_SHIFT_DONE_EN.
module mult_operand_shifter
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input logic                    clk,
    input logic                    rst,
    mult_operand_shifter_if.slave  bus
);

    localparam int PROD_W = 2 * WIDTH - 1;

    logic [PROD_W-1:0] left_q;
    logic [WIDTH-1:0]  right_q;

    shift_reg_1b #(
        .REG_W (PROD_W),
        .IN_W  (WIDTH),
        .DIR   (SHIFT_LEFT)
    ) u_left (
        .clk      (clk),
        .rst      (rst),
        .load     (bus.load),
        .shift_en (bus.shift_en),
        .din      (bus.multiplicand),
        .q        (left_q)
    );

    shift_reg_1b #(
        .REG_W (WIDTH),
        .IN_W  (WIDTH),
        .DIR   (SHIFT_RIGHT)
    ) u_right (
        .clk      (clk),
        .rst      (rst),
        .load     (bus.load),
        .shift_en (bus.shift_en),
        .din      (bus.multiplier),
        .q        (right_q)
    );

    logic zflag_int;

    assign zflag_int                = (right_q == '0);
    assign bus.shifted_multiplicand = left_q;
    assign bus.shifted_multiplier   = right_q;
    assign bus.lsb_multiplier       = right_q[0];
    assign bus.zflag                = zflag_int;

`ifdef MULT_SHIFT_DONE_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] shift_cnt;

    // Saturates at WIDTH so done stays asserted while the controller keeps shifting.
    always_ff @(posedge clk) begin
        if (rst || bus.load) begin
            shift_cnt <= '0;
        end else if (bus.shift_en && (shift_cnt != CNT_W'(WIDTH))) begin
            shift_cnt <= shift_cnt + 1'b1;
        end
    end

    assign bus.done = (shift_cnt == CNT_W'(WIDTH)) || zflag_int;
`endif

endmodule

// File: tb/tb_mult_operand_shifter.sv
// Self-checking bench for mult_operand_shifter: directed steps plus randomized traffic against
// an arithmetic model (operand << k, operand >> k). Define MULT_SHIFT_DONE_EN to also check done.
module tb_mult_operand_shifter;
    import mult_pkg::*;

    localparam int W  = MULT_WIDTH;
    localparam int PW = MULT_PROD_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mult_operand_shifter_if #(.WIDTH(W)) bus ();

    mult_operand_shifter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: captured operands and number of shifts since the last load/reset.
    longint m_a = 0;
    longint m_b = 0;
    int     m_k = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint exp_left();
        if (m_k >= PW) return 0;
        return (m_a << m_k) & ((longint'(1) << PW) - 1);
    endfunction

    function automatic longint exp_right();
        if (m_k >= W) return 0;
        return m_b >> m_k;
    endfunction

    task automatic check_all(input string tag);
        longint r;
        r = exp_right();
        check({tag, ".smcand"}, 64'(bus.shifted_multiplicand), 64'(exp_left()));
        check({tag, ".smplier"}, 64'(bus.shifted_multiplier), 64'(r));
        check({tag, ".lsb"}, 64'(bus.lsb_multiplier), 64'(r[0]));
        check({tag, ".zflag"}, 64'(bus.zflag), 64'(r == 0));
`ifdef MULT_SHIFT_DONE_EN
        check({tag, ".done"}, 64'(bus.done), 64'((m_k >= W) || (r == 0)));
`endif
    endtask

    task automatic step(input string tag, input bit r, input bit ld, input bit sh,
                        input operand_t mc, input operand_t mp);
        rst              = r;
        bus.load         = ld;
        bus.shift_en     = sh;
        bus.multiplicand = mc;
        bus.multiplier   = mp;
        @(posedge clk);
        #1;
        if (r) begin
            m_a = 0; m_b = 0; m_k = 0;
        end else if (ld) begin
            m_a = longint'(mc); m_b = longint'(mp); m_k = 0;
        end else if (sh) begin
            if (m_k < 40) m_k++;
        end
        check_all(tag);
    endtask

    // Walk one full multiplication and compare the accumulated addends with a*b.
    task automatic product_run(input string tag, input operand_t a, input operand_t b);
        longint sum;
        sum = 0;
        step({tag, ".load"}, 1'b0, 1'b1, 1'b0, a, b);
        for (int i = 0; i <= W; i++) begin
            if (bus.lsb_multiplier) sum += longint'(bus.shifted_multiplicand);
            if (i < W) step({tag, ".sh"}, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        end
        check({tag, ".product"}, 64'(sum), 64'(longint'(a) * longint'(b)));
    endtask

    initial begin
        bus.load = 1'b0; bus.shift_en = 1'b0;
        bus.multiplicand = '0; bus.multiplier = '0;

        // Reset overrides a simultaneous load.
        step("rst_with_load", 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
        check("rst.smcand_const", 64'(bus.shifted_multiplicand), 64'h0);
        check("rst.zflag_const", 64'(bus.zflag), 64'h1);

        step("load_0b_0d", 1'b0, 1'b1, 1'b0, 8'h0B, 8'h0D);
        check("load.smcand_const", 64'(bus.shifted_multiplicand), 64'h000B);
        check("load.smplier_const", 64'(bus.shifted_multiplier), 64'h0D);
        step("sh1", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        check("sh1.smcand_const", 64'(bus.shifted_multiplicand), 64'h16);
        step("sh2", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        step("sh3", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        step("sh4", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        check("sh4.smcand_const", 64'(bus.shifted_multiplicand), 64'hB0);
        check("sh4.zflag_const", 64'(bus.zflag), 64'h1);
        step("hold", 1'b0, 1'b0, 1'b0, 8'h55, 8'h55);

        product_run("prod_11x13", 8'h0B, 8'h0D);

        // Load wins over shift; reset wins over shift.
        step("prio_load", 1'b0, 1'b1, 1'b1, 8'h03, 8'h80);
        check("prio.smplier_const", 64'(bus.shifted_multiplier), 64'h80);
        step("prio_rst", 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);

        step("sat_load", 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
        for (int i = 0; i < W - 1; i++) begin
            step("sat_sh", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
`ifdef MULT_SHIFT_DONE_EN
            check("sat.done_low", 64'(bus.done), 64'h0);
`endif
        end
        check("sat7.smcand_const", 64'(bus.shifted_multiplicand), 64'h7F80);
        check("sat7.smplier_const", 64'(bus.shifted_multiplier), 64'h01);
        step("sat_sh8", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        check("sat8.smcand_const", 64'(bus.shifted_multiplicand), 64'h7F00);
        check("sat8.zflag_const", 64'(bus.zflag), 64'h1);
`ifdef MULT_SHIFT_DONE_EN
        check("sat8.done_high", 64'(bus.done), 64'h1);
`endif
        step("sat_sh9", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        step("sat_reload", 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
`ifdef MULT_SHIFT_DONE_EN
        check("reload.done_clear", 64'(bus.done), 64'h0);
`endif

        for (int i = 0; i < 8; i++) begin
            product_run("prod_rand", operand_t'($urandom), operand_t'($urandom));
        end

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(31) == 0), ($urandom_range(5) == 0),
                 $urandom_range(1) == 1, operand_t'($urandom), operand_t'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
